// File: rtl/bus_arbiter.sv
// Merges an instruction-fetch port and a data port onto one memory port, with
// at most one transaction outstanding. Round-robin (FAIR=1) or dmem-first (FAIR=0).
module bus_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Handshake: *_valid and *_ready are single-cycle pulses. A port valid is
  // accepted only while that port is neither pending nor granted (or in the
  // cycle its own ready fires); mem_valid pulses once per grant and the
  // matching port ready is mem_ready passed through combinationally.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic        i_pend;
  logic [31:0] i_addr_q;
  logic        d_pend;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic [3:0]  d_wstrb_q;
  logic        last_d;

  logic        busy_i;
  logic        busy_d;
  logic        arb_open;
  logic        i_accept;
  logic        d_accept;
  logic        i_elig;
  logic        d_elig;
  logic        grant_i;
  logic        grant_d;
  logic [31:0] i_addr_sel;
  logic [31:0] d_addr_sel;
  logic [31:0] d_wdata_sel;
  logic [3:0]  d_wstrb_sel;

  assign busy_i = (state == BUSY_I);
  assign busy_d = (state == BUSY_D);

  // The completion cycle of a busy state arbitrates exactly like IDLE.
  assign arb_open = !(busy_i || busy_d) || mem_ready;

  assign i_accept = imem_valid && !i_pend && (!busy_i || mem_ready);
  assign d_accept = dmem_valid && !d_pend && (!busy_d || mem_ready);
  assign i_elig   = i_pend || i_accept;
  assign d_elig   = d_pend || d_accept;

  // A request granted in its arrival cycle bypasses the request register.
  assign i_addr_sel  = i_pend ? i_addr_q  : imem_addr;
  assign d_addr_sel  = d_pend ? d_addr_q  : dmem_addr;
  assign d_wdata_sel = d_pend ? d_wdata_q : dmem_wdata;
  assign d_wstrb_sel = d_pend ? d_wstrb_q : dmem_wstrb;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    if (arb_open) begin
      state_next = IDLE;
      if (i_elig && d_elig) begin
        grant_i = (FAIR != 0) && last_d;
        grant_d = !((FAIR != 0) && last_d);
      end else if (i_elig) begin
        grant_i = 1'b1;
      end else if (d_elig) begin
        grant_d = 1'b1;
      end
      if (grant_i) begin
        state_next = BUSY_I;
      end else if (grant_d) begin
        state_next = BUSY_D;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      i_pend    <= 1'b0;
      i_addr_q  <= '0;
      d_pend    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
      last_d    <= 1'b1;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_valid <= grant_i || grant_d;

      if (i_accept) begin
        i_addr_q <= imem_addr;
      end
      if (d_accept) begin
        d_addr_q  <= dmem_addr;
        d_wdata_q <= dmem_wdata;
        d_wstrb_q <= dmem_wstrb;
      end

      if (grant_i) begin
        i_pend <= 1'b0;
      end else if (i_accept) begin
        i_pend <= 1'b1;
      end
      if (grant_d) begin
        d_pend <= 1'b0;
      end else if (d_accept) begin
        d_pend <= 1'b1;
      end

      // mem_* payload holds between grants; fetches always carry wstrb=0.
      if (grant_i) begin
        mem_instr <= 1'b1;
        mem_addr  <= i_addr_sel & 32'hFFFF_FFFC;
        mem_wdata <= '0;
        mem_wstrb <= '0;
        last_d    <= 1'b0;
      end else if (grant_d) begin
        mem_instr <= 1'b0;
        mem_addr  <= d_addr_sel & 32'hFFFF_FFFC;
        mem_wdata <= d_wdata_sel;
        mem_wstrb <= d_wstrb_sel;
        last_d    <= 1'b1;
      end
    end
  end

  assign imem_ready = busy_i && mem_ready;
  assign dmem_ready = busy_d && mem_ready;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a FAIR=1 instance and a FAIR=0 instance share all
// inputs; issued mem transactions and read data are scoreboarded through queues.
module tb_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  logic [31:0] f0_imem_rdata;
  logic        f0_imem_ready;
  logic [31:0] f0_dmem_rdata;
  logic        f0_dmem_ready;
  logic        f0_mem_valid;
  logic        f0_mem_instr;
  logic [31:0] f0_mem_addr;
  logic [31:0] f0_mem_wdata;
  logic [3:0]  f0_mem_wstrb;

  int checks   = 0;
  int failures = 0;

  // {instr, addr, wdata, wstrb}
  logic [68:0] exp_q[$];
  logic [31:0] rd_q[$];

  bus_arbiter #(.FAIR(1)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  bus_arbiter #(.FAIR(0)) dut0 (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rdata(f0_imem_rdata), .imem_ready(f0_imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(f0_dmem_rdata), .dmem_ready(f0_dmem_ready),
    .mem_valid(f0_mem_valid), .mem_instr(f0_mem_instr), .mem_addr(f0_mem_addr),
    .mem_wdata(f0_mem_wdata), .mem_wstrb(f0_mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    imem_valid = 1'b0;
    imem_addr  = '0;
    dmem_valid = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic test_reset();
    logic [1:0] st;
    do_reset();
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_0040;
    cyc();
    imem_valid = 1'b0;
    st = dut.state;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== 70'd0) begin
      failures++;
      $display("FAIL reset_mem_outputs: got valid=%b instr=%b addr=%h wdata=%h wstrb=%h, want all 0",
               mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if (st !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d, want 0 (IDLE)", st);
    end
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== 66'd0) begin
      failures++;
      $display("FAIL reset_ready: got iready=%b dready=%b, want 0", imem_ready, dmem_ready);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_capture: got mem_valid=%b, want 0", mem_valid);
    end
  endtask

  task automatic test_single_fetch();
    logic [68:0] e;
    do_reset();
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_1003;
    exp_q.push_back({1'b1, 32'h0000_1000, 32'h0, 4'h0});
    cyc();
    imem_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, e}) begin
      failures++;
      $display("FAIL fetch_issue: got valid=%b instr=%b addr=%h wstrb=%h, want valid=1 exp=%h",
               mem_valid, mem_instr, mem_addr, mem_wstrb, e);
    end
    cyc();
    checks++;
    if ({mem_valid, mem_instr, mem_addr} !== {1'b0, 1'b1, 32'h0000_1000}) begin
      failures++;
      $display("FAIL fetch_pulse_hold: got valid=%b instr=%b addr=%h, want 0/1/00001000",
               mem_valid, mem_instr, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    rd_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== {1'b1, 1'b0, rd_q.pop_front(), 32'h0}) begin
      failures++;
      $display("FAIL fetch_ready: got iready=%b dready=%b irdata=%h drdata=%h, want 1/0/deadbeef/0",
               imem_ready, dmem_ready, imem_rdata, dmem_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    checks++;
    if ({imem_ready, mem_valid} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_after: got iready=%b mem_valid=%b, want 0/0", imem_ready, mem_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [68:0] e;
    do_reset();
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_3004;
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_2000;
    dmem_wdata = 32'h1234_5678;
    dmem_wstrb = 4'hF;
    exp_q.push_back({1'b1, 32'h0000_3004, 32'h0, 4'h0});
    exp_q.push_back({1'b0, 32'h0000_2000, 32'h1234_5678, 4'hF});
    cyc();
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, e}) begin
      failures++;
      $display("FAIL tie_first_imem: got valid=%b instr=%b addr=%h, want imem exp=%h",
               mem_valid, mem_instr, mem_addr, e);
    end
    cyc();
    cyc();
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_0001;
    rd_q.push_back(32'hA5A5_0001);
    #1;
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata} !== {1'b1, 1'b0, rd_q.pop_front()}) begin
      failures++;
      $display("FAIL tie_imem_ready: got iready=%b dready=%b irdata=%h", imem_ready, dmem_ready, imem_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, e}) begin
      failures++;
      $display("FAIL tie_dmem_b2b: got valid=%b instr=%b addr=%h wdata=%h wstrb=%h, want exp=%h",
               mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, e);
    end
    cyc();
    mem_ready = 1'b1;
    mem_rdata = 32'h5A5A_0002;
    rd_q.push_back(32'h5A5A_0002);
    #1;
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== {1'b0, 1'b1, 32'h0, rd_q.pop_front()}) begin
      failures++;
      $display("FAIL tie_dmem_ready: got iready=%b dready=%b irdata=%h drdata=%h",
               imem_ready, dmem_ready, imem_rdata, dmem_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_fairness();
    logic [68:0] e;
    logic [31:0] r;
    int w;
    do_reset();
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_0100;
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_0200;
    dmem_wdata = 32'h0;
    dmem_wstrb = 4'h0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) exp_q.push_back({1'b1, 32'h0000_0100, 32'h0, 4'h0});
      else            exp_q.push_back({1'b0, 32'h0000_0200, 32'h0, 4'h0});
    end
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (mem_valid !== 1'b1 && w < 10) begin
        cyc();
        w++;
      end
      checks++;
      if (mem_valid !== 1'b1) begin
        failures++;
        $display("FAIL fair_timeout: no mem_valid for grant %0d", k);
        break;
      end
      e = exp_q.pop_front();
      checks++;
      if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !== e) begin
        failures++;
        $display("FAIL fair_grant_%0d: got instr=%b addr=%h, want exp=%h", k, mem_instr, mem_addr, e);
      end
      checks++;
      if ({f0_mem_valid, f0_mem_instr, f0_mem_addr} !== {1'b1, 1'b0, 32'h0000_0200}) begin
        failures++;
        $display("FAIL fixed_grant_%0d: got valid=%b instr=%b addr=%h, want 1/0/00000200",
                 k, f0_mem_valid, f0_mem_instr, f0_mem_addr);
      end
      repeat ($urandom_range(1, 3)) cyc();
      r = $urandom;
      mem_ready = 1'b1;
      mem_rdata = r;
      rd_q.push_back(r);
      #1;
      r = rd_q.pop_front();
      checks++;
      if (e[68] ? ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== {2'b10, r, 32'h0})
                : ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== {2'b01, 32'h0, r})) begin
        failures++;
        $display("FAIL fair_ready_%0d: got iready=%b dready=%b irdata=%h drdata=%h, want data %h on %s",
                 k, imem_ready, dmem_ready, imem_rdata, dmem_rdata, r, e[68] ? "imem" : "dmem");
      end
      cyc();
      mem_ready = 1'b0;
    end
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
  endtask

  task automatic test_pending();
    logic [68:0] e;
    int extra;
    do_reset();
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_3000;
    exp_q.push_back({1'b1, 32'h0000_3000, 32'h0, 4'h0});
    cyc();
    imem_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, e}) begin
      failures++;
      $display("FAIL pend_imem_issue: got valid=%b instr=%b addr=%h", mem_valid, mem_instr, mem_addr);
    end
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_4009;
    dmem_wdata = 32'hCAFE_0001;
    dmem_wstrb = 4'h3;
    exp_q.push_back({1'b0, 32'h0000_4008, 32'hCAFE_0001, 4'h3});
    cyc();
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_5000;
    dmem_wdata = 32'h0000_0011;
    dmem_wstrb = 4'hF;
    checks++;
    if (mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL pend_held: got mem_valid=%b while busy, want 0", mem_valid);
    end
    cyc();
    dmem_valid = 1'b0;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h0000_0077;
    #1;
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata} !== {2'b10, 32'h0000_0077}) begin
      failures++;
      $display("FAIL pend_imem_ready: got iready=%b dready=%b irdata=%h", imem_ready, dmem_ready, imem_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, e}) begin
      failures++;
      $display("FAIL pend_dmem_issue: got valid=%b instr=%b addr=%h wdata=%h wstrb=%h, want exp=%h",
               mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, e);
    end
    cyc();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0088;
    #1;
    checks++;
    if ({imem_ready, dmem_ready, dmem_rdata} !== {2'b01, 32'h0000_0088}) begin
      failures++;
      $display("FAIL pend_dmem_ready: got iready=%b dready=%b drdata=%h", imem_ready, dmem_ready, dmem_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    extra = 0;
    repeat (6) begin
      if (mem_valid === 1'b1) extra++;
      cyc();
    end
    checks++;
    if (extra != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL pend_no_extra: got %0d extra mem_valid, %0d unissued, want 0/0", extra, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] st;
    int extra;
    do_reset();
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({imem_ready, dmem_ready} !== 2'b00) begin
      failures++;
      $display("FAIL idle_ready_ignored: got iready=%b dready=%b, want 0/0", imem_ready, dmem_ready);
    end
    cyc();
    mem_ready  = 1'b0;
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_6000;
    dmem_wdata = 32'h0000_ABCD;
    dmem_wstrb = 4'hF;
    cyc();
    dmem_valid = 1'b0;
    checks++;
    if ({mem_valid, mem_instr, mem_addr} !== {1'b1, 1'b0, 32'h0000_6000}) begin
      failures++;
      $display("FAIL rmid_issue: got valid=%b instr=%b addr=%h", mem_valid, mem_instr, mem_addr);
    end
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_7000;
    cyc();
    imem_valid = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0099;
    #1;
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== 66'd0) begin
      failures++;
      $display("FAIL rmid_no_ready: got iready=%b dready=%b drdata=%h, want 0", imem_ready, dmem_ready, dmem_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    st = dut.state;
    checks++;
    if ({mem_valid, st} !== 3'b000) begin
      failures++;
      $display("FAIL rmid_idle: got mem_valid=%b state=%0d, want 0/IDLE", mem_valid, st);
    end
    extra = 0;
    repeat (4) begin
      if (mem_valid === 1'b1) extra++;
      cyc();
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL rmid_dropped: got %0d mem_valid after reset, want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_fairness();
    test_pending();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter FAIR, default 1; 1 = round-robin between ports, 0 = fixed priority with dmem winning.
REQ-002 Ports (name  direction  width  meaning):
- clock  in  1  clock; reset  in  1  reset, synchronous, active-low.
- imem_valid  in  1  fetch request pulse; imem_addr  in  32  fetch address.
- imem_rdata  out  32  fetch data; imem_ready  out  1  fetch completion pulse.
- dmem_valid  in  1  data request pulse; dmem_addr  in  32  data address; dmem_wdata  in  32  store data.
- dmem_wstrb  in  4  byte strobes, 0 = load; dmem_rdata  out  32  load data; dmem_ready  out  1  data completion pulse.
- mem_valid  out  1  request pulse to AXI bridge; mem_instr  out  1  1 = fetch; mem_addr  out  32  address; mem_wdata  out  32  store data; mem_wstrb  out  4  byte strobes.
- mem_rdata  in  32  bridge read data; mem_ready  in  1  bridge completion pulse.

Function
REQ-003 The block SHALL merge the imem and dmem ports onto the single mem port, with at most one transaction outstanding on mem.
REQ-004 The block SHALL implement states IDLE, BUSY_I and BUSY_D.
REQ-005 Each port SHALL have a pending flag plus a request register (addr, wdata, wstrb); imem requests SHALL be stored with wstrb=0.
REQ-006 A valid pulse on a port with a clear pending flag and no grant SHALL be captured into that port's request register in its arrival cycle, in any state.
REQ-007 A valid pulse on a port that is already pending or granted SHALL be ignored (protocol violation).
REQ-008 A port is eligible in IDLE when its pending flag is set or its valid is high that cycle.
REQ-009 In IDLE with one eligible port, that port SHALL be granted.
REQ-010 In IDLE with both ports eligible: FAIR=1 SHALL grant the port not granted last; FAIR=0 SHALL grant dmem.
REQ-011 On grant, next cycle: state = BUSY_I or BUSY_D; mem_valid = 1 for exactly that one cycle; mem_addr = {addr[31:2],2'b00}; mem_wdata and mem_wstrb loaded from the granted request; mem_instr = 1 for imem, 0 for dmem; the granted port's pending flag cleared; last-grant updated.
REQ-012 mem_addr, mem_wdata, mem_wstrb and mem_instr SHALL hold their values until the next grant.
REQ-013 In BUSY_x, a cycle with mem_ready=1 SHALL drive x_ready=1 and x_rdata=mem_rdata combinationally in that cycle, and the state SHALL return to IDLE next cycle.
REQ-014 The other port's ready SHALL stay 0 and its rdata SHALL stay 0 in every cycle.
REQ-015 In the mem_ready cycle the next grant SHALL be evaluated as in IDLE, so a waiting request drives mem_valid the following cycle (back-to-back, zero bubble).
REQ-016 A valid pulse arriving on a port in the same cycle as that port's ready SHALL be captured as a new request.
REQ-017 mem_ready while in IDLE SHALL be ignored.
REQ-018 Latency: request into an idle arbiter -> mem_valid 1 cycle later; mem_ready -> port ready 0 cycles.

Reset
REQ-019 While reset=0 at a clock edge: state = IDLE; pending flags, request registers and mem_* outputs = 0; last-grant = dmem, so imem wins the first tie.
REQ-020 Reset mid-transaction SHALL drop every pending and granted request; no ready pulse SHALL be produced for a dropped request, even if mem_ready arrives afterwards.

Verification
REQ-021 Single fetch: imem_valid pulse, addr 0x0000_1003 -> next cycle mem_valid=1, mem_addr=0x0000_1000, mem_instr=1, mem_wstrb=0; later mem_ready with mem_rdata=0xDEAD_BEEF -> same cycle imem_ready=1, imem_rdata=0xDEAD_BEEF.
REQ-022 Simultaneous pulses after reset, FAIR=1: imem granted first; dmem (addr 0x2000, wstrb 0xF, wdata 0x1234_5678) issued on mem the cycle after imem's mem_ready, with mem_instr=0.
REQ-023 FAIR=0 with both ports always re-requesting: every grant goes to dmem while dmem is pending; FAIR=1 with the same stimulus: grants alternate I, D, I, D.
REQ-024 dmem pulse while BUSY_I -> held pending, then issued one cycle after the imem completion; a second dmem pulse while pending -> no extra mem_valid.
REQ-025 reset=0 asserted while BUSY_D, then mem_ready=1 -> dmem_ready stays 0, mem_valid stays 0, state is IDLE.
